// File: rtl/alu_muldiv_unit_pkg.sv
// Shared codes for the execute-stage ALU: ALU-op selectors, funct values and
// the mul/div engine state encoding.
package alu_muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

endpackage

// File: rtl/alu_muldiv_unit_if.sv
// Issue/result bundle between the ID/EX stage and the execute ALU.
interface alu_muldiv_unit_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic             out_valid;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, alu_op, funct, a, b,
        input  in_ready, result, zero, overflow, illegal, out_valid, busy, hi, lo
    );

    modport slave (
        input  in_valid, alu_op, funct, a, b,
        output in_ready, result, zero, overflow, illegal, out_valid, busy, hi, lo
    );
endinterface

// File: rtl/alu_muldiv_unit_muldiv_iter.sv
// Iterative MIPS-style multiply/divide engine: magnitudes in, WIDTH shift-add or
// restoring-subtract steps, then sign correction. op[1] = divide, op[0] = unsigned.
module muldiv_iter
    import alu_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_if2(input logic n, input logic [2*WIDTH-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

    md_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_m;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic               r_busy;
    logic               r_done;

    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_amag;
    logic [WIDTH-1:0] w_bmag;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_trial;
    logic [2*WIDTH-1:0] w_prod;

    assign w_sa   = !op[0] && a[WIDTH-1];
    assign w_sb   = !op[0] && b[WIDTH-1];
    assign w_amag = neg_if(w_sa, a);
    assign w_bmag = neg_if(w_sb, b);

    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_m};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE, MD_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Multiplier (or dividend) sits in the low half; r_m is the other operand.
                        r_acc    <= {{WIDTH{1'b0}}, op[1] ? w_amag : w_bmag};
                        r_m      <= op[1] ? w_bmag : w_amag;
                        r_is_div <= op[1];
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_dz     <= (b == '0);
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= MD_RUN;
                    end else begin
                        r_state  <= MD_IDLE;
                    end
                end
                MD_RUN: begin
                    if (r_is_div)
                        r_acc <= w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                                    : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                    else
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= MD_FIX;
                        r_done  <= 1'b1;
                    end
                end
                MD_FIX: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= MD_DONE;
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    // Sign correction is applied on the accumulator while in FIX; the parent captures it.
    assign w_prod = neg_if2(r_neg_q, r_acc);

    always_comb begin
        hi_out = w_prod[2*WIDTH-1:WIDTH];
        lo_out = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            hi_out = neg_if(r_neg_r, r_acc[2*WIDTH-1:WIDTH]);
            lo_out = r_dz ? '1 : neg_if(r_neg_q, r_acc[WIDTH-1:0]);
        end
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: rtl/alu_muldiv_unit.sv
// Execute-stage ALU: ALU-op/funct decode, single-cycle datapath, HI/LO registers
// and registered result outputs, with an iterative mul/div engine alongside.
module alu_muldiv_unit
    import alu_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_muldiv_unit_if.slave bus
);

    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    logic [5:0]              w_fn;
    logic                    w_acc;
    logic                    w_is_md;
    logic [WIDTH-1:0]        w_res;
    logic                    w_ovf;
    logic                    w_ill;
    logic                    w_we_hi;
    logic                    w_we_lo;
    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_b_s;
    logic signed [WIDTH-1:0] w_sum;
    logic signed [WIDTH-1:0] w_diff;
    logic                    w_md_busy;
    logic                    w_md_done;
    logic [WIDTH-1:0]        w_md_hi;
    logic [WIDTH-1:0]        w_md_lo;

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_result_p1;
    logic             r_zero_p1;
    logic             r_ovf_p1;
    logic             r_ill_p1;
    logic             r_vld_p1;

    assign w_a_s  = bus.a;
    assign w_b_s  = bus.b;
    assign w_sum  = w_a_s + w_b_s;
    assign w_diff = w_a_s - w_b_s;
    assign w_acc  = bus.in_valid && !w_md_busy;

    always_comb begin
        case (bus.alu_op)
            ALUOP_ADD:   w_fn = FUNCT_ADDU;
            ALUOP_SUB:   w_fn = FUNCT_SUBU;
            ALUOP_FUNCT: w_fn = bus.funct;
            default:     w_fn = FUNCT_OR;
        endcase
    end

    always_comb begin
        w_res   = '0;
        w_ovf   = 1'b0;
        w_ill   = 1'b0;
        w_we_hi = 1'b0;
        w_we_lo = 1'b0;
        w_is_md = 1'b0;
        case (w_fn)
            FUNCT_ADD:  begin w_res = w_sum;  w_ovf = add_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], w_sum[WIDTH-1]); end
            FUNCT_ADDU: w_res = w_sum;
            FUNCT_SUB:  begin w_res = w_diff; w_ovf = add_ovf(bus.a[WIDTH-1], !bus.b[WIDTH-1], w_diff[WIDTH-1]); end
            FUNCT_SUBU: w_res = w_diff;
            FUNCT_AND:  w_res = bus.a & bus.b;
            FUNCT_OR:   w_res = bus.a | bus.b;
            FUNCT_XOR:  w_res = bus.a ^ bus.b;
            FUNCT_NOR:  w_res = ~(bus.a | bus.b);
            FUNCT_SLT:  w_res[0] = (w_a_s < w_b_s);
            FUNCT_SLTU: w_res[0] = (bus.a < bus.b);
            FUNCT_MFHI: w_res = r_hi;
            FUNCT_MFLO: w_res = r_lo;
            FUNCT_MTHI: begin w_res = bus.a; w_we_hi = 1'b1; end
            FUNCT_MTLO: begin w_res = bus.a; w_we_lo = 1'b1; end
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: w_is_md = 1'b1;
            default:    w_ill = 1'b1;
        endcase
    end

    muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_acc && w_is_md),
        .op     (w_fn[1:0]),
        .a      (bus.a),
        .b      (bus.b),
        .busy   (w_md_busy),
        .done   (w_md_done),
        .hi_out (w_md_hi),
        .lo_out (w_md_lo)
    );

    // ---- stage p1: registered results; engine completion and accepts never coincide ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi        <= '0;
            r_lo        <= '0;
            r_result_p1 <= '0;
            r_zero_p1   <= 1'b1;
            r_ovf_p1    <= 1'b0;
            r_ill_p1    <= 1'b0;
            r_vld_p1    <= 1'b0;
        end else begin
            r_vld_p1 <= 1'b0;
            if (w_md_done) begin
                r_hi        <= w_md_hi;
                r_lo        <= w_md_lo;
                r_result_p1 <= w_md_lo;
                r_zero_p1   <= (w_md_lo == '0);
                r_ovf_p1    <= 1'b0;
                r_ill_p1    <= 1'b0;
                r_vld_p1    <= 1'b1;
            end else if (w_acc && !w_is_md) begin
                if (w_we_hi) r_hi <= bus.a;
                if (w_we_lo) r_lo <= bus.a;
                r_result_p1 <= w_res;
                r_zero_p1   <= (w_res == '0);
                r_ovf_p1    <= w_ovf;
                r_ill_p1    <= w_ill;
                r_vld_p1    <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = !w_md_busy;
    assign bus.busy      = w_md_busy;
    assign bus.result    = r_result_p1;
    assign bus.zero      = r_zero_p1;
    assign bus.overflow  = r_ovf_p1;
    assign bus.illegal   = r_ill_p1;
    assign bus.out_valid = r_vld_p1;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Scoreboard bench for alu_muldiv_unit: directed vectors push expectations,
// a negedge monitor pops and compares on every out_valid.
module tb_alu_muldiv_unit;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        il;
        logic        chk_hl;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t mon_e;

    alu_muldiv_unit_if #(.WIDTH(32)) bus ();

    alu_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out_valid: actual result %h required no output", bus.result);
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("v%0d_result", mon_e.id), 64'(bus.result), 64'(mon_e.res));
                chk($sformatf("v%0d_zero", mon_e.id), 64'(bus.zero), 64'(mon_e.z));
                chk($sformatf("v%0d_overflow", mon_e.id), 64'(bus.overflow), 64'(mon_e.ov));
                chk($sformatf("v%0d_illegal", mon_e.id), 64'(bus.illegal), 64'(mon_e.il));
                chk($sformatf("v%0d_latency_cycle", mon_e.id), 64'(cyc), 64'(mon_e.cyc));
                if (mon_e.chk_hl) begin
                    chk($sformatf("v%0d_hi", mon_e.id), 64'(bus.hi), 64'(mon_e.hi));
                    chk($sformatf("v%0d_lo", mon_e.id), 64'(bus.lo), 64'(mon_e.lo));
                end
            end
        end
    end

    // Called at a negedge; offers the op until accepted, then drops in_valid a cycle later.
    task automatic send(input int id, input logic [1:0] aop, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input int lat,
                        input logic [31:0] res, input logic z, input logic ov, input logic il,
                        input logic chk_hl, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        int   k;
        bus.in_valid = 1'b1;
        bus.alu_op   = aop;
        bus.funct    = fn;
        bus.a        = a;
        bus.b        = b;
        k = 0;
        while (!bus.in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL v%0d_accept_timeout: actual in_ready 0 required 1", id);
        end else if (lat > 0) begin
            e.id = id; e.res = res; e.z = z; e.ov = ov; e.il = il;
            e.chk_hl = chk_hl; e.hi = hi; e.lo = lo; e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: actual %0d pending required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual time %0t required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with an offer present
        bus.in_valid = 1'b1;
        bus.alu_op   = 2'b10;
        bus.funct    = 6'h20;
        bus.a        = 32'd1;
        bus.b        = 32'd2;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_hi", 64'(bus.hi), 64'd0);
        chk("reset_lo", 64'(bus.lo), 64'd0);
        chk("reset_zero", 64'(bus.zero), 64'd1);
        chk("reset_result", 64'(bus.result), 64'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle ALU ops, back to back
        send(1,  2'b10, 6'h20, 32'h7FFFFFFF, 32'h1, 1, 32'h80000000, 0, 1, 0, 0, 0, 0);
        send(2,  2'b10, 6'h21, 32'h7FFFFFFF, 32'h1, 1, 32'h80000000, 0, 0, 0, 0, 0, 0);
        send(3,  2'b10, 6'h2A, 32'hFFFFFFFF, 32'h1, 1, 32'h1,        0, 0, 0, 0, 0, 0);
        send(4,  2'b10, 6'h2B, 32'hFFFFFFFF, 32'h1, 1, 32'h0,        1, 0, 0, 0, 0, 0);
        send(5,  2'b10, 6'h27, 32'h0,        32'h0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
        send(6,  2'b10, 6'h22, 32'h5,        32'h5, 1, 32'h0,        1, 0, 0, 0, 0, 0);
        send(7,  2'b10, 6'h22, 32'h80000000, 32'h1, 1, 32'h7FFFFFFF, 0, 1, 0, 0, 0, 0);
        send(8,  2'b00, 6'h3F, 32'h7FFFFFFF, 32'h1, 1, 32'h80000000, 0, 0, 0, 0, 0, 0);
        send(9,  2'b01, 6'h3F, 32'h3,        32'h5, 1, 32'hFFFFFFFE, 0, 0, 0, 0, 0, 0);
        send(10, 2'b11, 6'h3F, 32'hF0,       32'h0F, 1, 32'hFF,      0, 0, 0, 0, 0, 0);
        send(11, 2'b10, 6'h24, 32'hFF00FF00, 32'h0FF00FF0, 1, 32'h0F000F00, 0, 0, 0, 0, 0, 0);
        send(12, 2'b10, 6'h26, 32'hFF00FF00, 32'h0FF00FF0, 1, 32'hF0F0F0F0, 0, 0, 0, 0, 0, 0);
        drain();

        // Multiply / divide, each next one accepted in the previous DONE cycle
        send(20, 2'b10, 6'h18, 32'hFFFFFFFD, 32'h7, 34, 32'hFFFFFFEB, 0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFEB);
        send(21, 2'b10, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'h1, 0, 0, 0, 1, 32'hFFFFFFFE, 32'h1);
        send(22, 2'b10, 6'h1A, 32'hFFFFFFF9, 32'h2, 34, 32'hFFFFFFFD, 0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFD);
        send(23, 2'b10, 6'h1B, 32'h7, 32'h0, 34, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h7, 32'hFFFFFFFF);
        send(24, 2'b10, 6'h1A, 32'h80000000, 32'hFFFFFFFF, 34, 32'h80000000, 0, 0, 0, 1, 32'h0, 32'h80000000);
        drain();

        // HI/LO moves and an unsupported funct that must leave HI/LO alone
        send(30, 2'b10, 6'h11, 32'h12345678, 32'h0, 1, 32'h12345678, 0, 0, 0, 1, 32'h12345678, 32'h80000000);
        send(31, 2'b10, 6'h13, 32'h0, 32'h0, 1, 32'h0, 1, 0, 0, 1, 32'h12345678, 32'h0);
        send(32, 2'b10, 6'h3F, 32'h5, 32'h6, 1, 32'h0, 1, 0, 1, 1, 32'h12345678, 32'h0);
        send(33, 2'b10, 6'h10, 32'h0, 32'h0, 1, 32'h12345678, 0, 0, 0, 1, 32'h12345678, 32'h0);
        drain();

        // Offers during a multiply are ignored; MFLO lands in the DONE cycle
        send(40, 2'b10, 6'h18, 32'h6, 32'h7, 34, 32'h2A, 0, 0, 0, 1, 32'h0, 32'h2A);
        chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
        chk("busy_flag", 64'(bus.busy), 64'd1);
        bus.in_valid = 1'b1;
        bus.alu_op   = 2'b10;
        bus.funct    = 6'h20;
        bus.a        = 32'h1;
        bus.b        = 32'h1;
        repeat (3) @(negedge clk);
        send(41, 2'b10, 6'h12, 32'h0, 32'h0, 1, 32'h2A, 0, 0, 0, 1, 32'h0, 32'h2A);
        drain();

        // Reset part-way through a divide discards it
        send(50, 2'b10, 6'h1A, 32'd100, 32'd3, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_busy", 64'(bus.busy), 64'd0);
        chk("midreset_hi", 64'(bus.hi), 64'd0);
        chk("midreset_lo", 64'(bus.lo), 64'd0);
        chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (40) @(negedge clk);
        send(51, 2'b10, 6'h3F, 32'h5, 32'h6, 1, 32'h0, 1, 0, 1, 1, 32'h0, 32'h0);
        drain();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
